// File: rtl/c_requant_pkg.sv
// Shared constants, FSM state type and per-lane requantisation config for c_requant.
package c_requant_pkg;

  localparam int unsigned LAT = 6;

  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;

  localparam logic signed [63:0] ROUND_NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] ROUND_NUDGE_NEG = -64'sd1073741823;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [31:0] mult;
    logic [5:0]  shift;
    logic [8:0]  offset;
    logic [7:0]  act_min;
    logic [7:0]  act_max;
  } lane_cfg_t;

endpackage

// File: rtl/c_requant_if.sv
// C-buffer read port and D-buffer write port seen by the requantiser.
interface c_requant_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic [ADDR_W-1:0] C_index;
  logic [127:0]      C_data_out;
  logic              D_wr_en;
  logic [ADDR_W-1:0] D_index;
  logic [31:0]       D_data_in;

  modport master (
    output C_index,
    input  C_data_out,
    output D_wr_en,
    output D_index,
    output D_data_in
  );

  modport slave (
    input  C_index,
    output C_data_out,
    input  D_wr_en,
    input  D_index,
    input  D_data_in
  );

endinterface

// File: rtl/c_requant_lane.sv
// Stages s2..s6 of one int32 lane: bias, left shift, doubling high-mul, rounding right shift,
// offset and clamp to int8.
module requant_lane
  import c_requant_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] acc,
  input  logic [31:0] bias,
  input  lane_cfg_t   cfg,
  output logic [7:0]  q
);

  logic [4:0]         lsh;
  logic [4:0]         rsh;
  logic [31:0]        x2;
  logic signed [63:0] p3;
  logic               sat3;
  logic [31:0]        v4;
  logic [31:0]        r5;

  logic signed [63:0] nudged;
  logic [31:0]        mask;
  logic [31:0]        rem;
  logic [31:0]        thr;
  logic signed [31:0] asr;
  logic signed [32:0] o6;

  assign lsh = cfg.shift[5] ? '0 : cfg.shift[4:0];
  assign rsh = cfg.shift[5] ? (~cfg.shift[4:0] + 5'd1) : '0;

  always_comb begin
    nudged = p3 + (p3[63] ? ROUND_NUDGE_NEG : ROUND_NUDGE_POS);
    mask   = (32'd1 << rsh) - 32'd1;
    rem    = v4 & mask;
    thr    = (mask >> 1) + {31'd0, v4[31]};
    asr    = $signed(v4) >>> rsh;
    o6     = {r5[31], r5} + {{24{cfg.offset[8]}}, cfg.offset};
  end

  // Division by 2^31 truncating toward zero: negative values are biased up before the shift.
  always_ff @(posedge clk) begin
    x2   <= (acc + bias) << lsh;
    p3   <= 64'($signed(x2)) * 64'($signed(cfg.mult));
    sat3 <= (x2 == INT32_MIN) && (cfg.mult == INT32_MIN);
    v4   <= sat3 ? INT32_MAX
                 : 32'(nudged[63] ? (nudged + 64'sd2147483647) >>> 31 : nudged >>> 31);
    r5   <= asr + {31'd0, (rem > thr)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (o6 < 33'($signed(cfg.act_min))) begin
      q <= cfg.act_min;
    end else if (o6 > 33'($signed(cfg.act_max))) begin
      q <= cfg.act_max;
    end else begin
      q <= o6[7:0];
    end
  end

endmodule

// File: rtl/c_requant.sv
// Requantisation output stage: streams C-buffer accumulator words through four lanes and
// writes packed int8 results to the D buffer at one word per cycle.
module c_requant
  import c_requant_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rows,
  input  logic [127:0]      bias,
  input  logic [31:0]       OutputMultiplier,
  input  logic [5:0]        OutputShift,
  input  logic [8:0]        OutputOffset,
  input  logic [7:0]        ActMin,
  input  logic [7:0]        ActMax,
  output logic              busy,
  c_requant_if.master       mem
);

  state_t            state;
  logic [ADDR_W-1:0] rows_q;
  logic [127:0]      bias_q;
  lane_cfg_t         cfg_q;
  logic              issue_v;
  logic [LAT-1:1]    vpipe;
  logic [ADDR_W-1:0] idx_q [1:LAT-1];
  logic [7:0]        lane_q [4];

  // Index 0 is issued on the start edge itself so the run takes rows + LAT + 1 busy cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mem.C_index <= '0;
      issue_v     <= 1'b0;
      vpipe       <= '0;
      for (int unsigned i = 1; i < LAT; i++) idx_q[i] <= '0;
      mem.D_wr_en <= 1'b0;
      mem.D_index <= '0;
      rows_q      <= '0;
      bias_q      <= '0;
      cfg_q       <= '0;
    end else begin
      vpipe    <= {vpipe[LAT-2:1], issue_v};
      idx_q[1] <= mem.C_index;
      for (int unsigned i = 2; i < LAT; i++) idx_q[i] <= idx_q[i-1];
      mem.D_wr_en <= vpipe[LAT-1];
      mem.D_index <= idx_q[LAT-1];

      unique case (state)
        IDLE: begin
          if (in_valid) begin
            rows_q        <= rows;
            bias_q        <= bias;
            cfg_q.mult    <= OutputMultiplier;
            cfg_q.shift   <= OutputShift;
            cfg_q.offset  <= OutputOffset;
            cfg_q.act_min <= ActMin;
            cfg_q.act_max <= ActMax;
            busy          <= 1'b1;
            if (rows == '0) begin
              state <= DONE;
            end else begin
              state       <= RUN;
              mem.C_index <= '0;
              issue_v     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mem.C_index == rows_q - ADDR_W'(1)) begin
            issue_v <= 1'b0;
            state   <= DRAIN;
          end else begin
            mem.C_index <= mem.C_index + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (vpipe == '0 && mem.D_wr_en) state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    requant_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .acc  (mem.C_data_out[127-32*l -: 32]),
      .bias (bias_q[127-32*l -: 32]),
      .cfg  (cfg_q),
      .q    (lane_q[l])
    );
  end

  assign mem.D_data_in = {lane_q[0], lane_q[1], lane_q[2], lane_q[3]};

endmodule
